// File: rtl/econet_tx_framer.sv
// Econet HDLC transmit framer: opening flags, LSB-first zero-stuffed data, CRC-CCITT FCS, closing flags.
// Build macro TX_IDLE_FLAGS_EN: the idle line carries continuous 0x7E flags instead of marks.
module econet_tx_framer #(
  parameter int LEAD_FLAGS  = 2,
  parameter int TRAIL_FLAGS = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       bit_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  input  logic       tx_last,
  output logic       tx_ready,
  input  logic       tx_abort,
  output logic       txd,
  output logic       tx_en,
  output logic       busy,
  output logic       done,
  output logic       underrun,
  output logic [2:0] fsm_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LEAD  = 3'd1,
    DATA  = 3'd2,
    FCS   = 3'd3,
    TRAIL = 3'd4,
    ABORT = 3'd5
  } state_t;

  localparam logic [7:0] FLAG = 8'h7E;

  state_t      state, state_n;
  logic [7:0]  shreg, shreg_n;
  logic [7:0]  hold, hold_n;
  logic        hold_full, hold_full_n;
  logic        hold_last, hold_last_n;
  logic        cur_last, cur_last_n;
  logic        last_acc, last_acc_n;
  logic [15:0] lfsr, lfsr_n;
  logic [2:0]  ones, ones_n;
  logic [2:0]  bit_cnt, bit_cnt_n;
  logic [4:0]  cnt, cnt_n;
  logic        txd_n, tx_en_n, done_n, underrun_n;
  logic        running;
  logic        reload, accept, abort_now, data_bit, fb, fcs_bit;
`ifdef TX_IDLE_FLAGS_EN
  logic [3:0]  idle_flags, idle_flags_n;
`endif

  assign busy      = (state != IDLE);
  assign fsm_state = state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= 8'h00;
      hold       <= 8'h00;
      hold_full  <= 1'b0;
      hold_last  <= 1'b0;
      cur_last   <= 1'b0;
      last_acc   <= 1'b0;
      lfsr       <= 16'hFFFF;
      ones       <= 3'd0;
      bit_cnt    <= 3'd0;
      cnt        <= 5'd0;
      txd        <= 1'b1;
      tx_en      <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      running    <= 1'b0;
`ifdef TX_IDLE_FLAGS_EN
      idle_flags <= 4'd0;
`endif
    end else begin
      shreg      <= shreg_n;
      hold       <= hold_n;
      hold_full  <= hold_full_n;
      hold_last  <= hold_last_n;
      cur_last   <= cur_last_n;
      last_acc   <= last_acc_n;
      lfsr       <= lfsr_n;
      ones       <= ones_n;
      bit_cnt    <= bit_cnt_n;
      cnt        <= cnt_n;
      txd        <= txd_n;
      tx_en      <= tx_en_n;
      done       <= done_n;
      underrun   <= underrun_n;
      running    <= 1'b1;
`ifdef TX_IDLE_FLAGS_EN
      idle_flags <= idle_flags_n;
`endif
    end
  end

  // Handshake: a byte moves when tx_valid && tx_ready are both high at a rising clk edge.
  // tx_ready never depends on tx_valid; it may rise for a single clk when a byte-boundary
  // reload frees the one-entry holding register in that same clk.
  always_comb begin
    state_n     = state;
    shreg_n     = shreg;
    hold_n      = hold;
    hold_full_n = hold_full;
    hold_last_n = hold_last;
    cur_last_n  = cur_last;
    last_acc_n  = last_acc;
    lfsr_n      = lfsr;
    ones_n      = ones;
    bit_cnt_n   = bit_cnt;
    cnt_n       = cnt;
    txd_n       = txd;
    tx_en_n     = tx_en;
    done_n      = 1'b0;
    underrun_n  = 1'b0;
    reload      = 1'b0;
    tx_ready    = 1'b0;
    accept      = 1'b0;
`ifdef TX_IDLE_FLAGS_EN
    idle_flags_n = idle_flags;
`endif
    data_bit  = shreg[0];
    fb        = data_bit ^ lfsr[15];
    fcs_bit   = ~lfsr[4'd15 - cnt[3:0]];
    abort_now = bit_en && tx_abort &&
                (state == LEAD || state == DATA || state == FCS);

    if (abort_now) begin
      // The cell that sees the abort already carries the first of the eight ones.
      state_n     = ABORT;
      cnt_n       = 5'd1;
      txd_n       = 1'b1;
      tx_en_n     = 1'b1;
      hold_full_n = 1'b0;
      ones_n      = 3'd0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
`ifdef TX_IDLE_FLAGS_EN
          txd_n     = FLAG[bit_cnt];
          tx_en_n   = 1'b1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (hold_full) begin
              idle_flags_n = 4'd0;
              if (({1'b0, idle_flags} + 5'd1) >= 5'(LEAD_FLAGS)) begin
                state_n = DATA;
                reload  = 1'b1;
              end else begin
                state_n = LEAD;
                cnt_n   = {1'b0, idle_flags + 4'd1};
              end
            end else if (idle_flags != 4'hF) begin
              idle_flags_n = idle_flags + 4'd1;
            end
          end
`else
          txd_n   = 1'b1;
          tx_en_n = 1'b0;
`endif
        end
        LEAD: begin
          txd_n     = FLAG[bit_cnt];
          tx_en_n   = 1'b1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (cnt == 5'(LEAD_FLAGS - 1)) begin
              state_n = DATA;
              reload  = 1'b1;
            end else begin
              cnt_n = cnt + 5'd1;
            end
          end
        end
        DATA: begin
          tx_en_n = 1'b1;
          if (ones == 3'd5) begin
            txd_n  = 1'b0;
            ones_n = 3'd0;
          end else begin
            txd_n     = data_bit;
            lfsr_n    = {lfsr[14:12], lfsr[11] ^ fb, lfsr[10:5], lfsr[4] ^ fb, lfsr[3:0], fb};
            ones_n    = data_bit ? ones + 3'd1 : 3'd0;
            shreg_n   = {1'b0, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (cur_last) begin
                state_n = FCS;
                cnt_n   = 5'd0;
              end else if (hold_full) begin
                reload = 1'b1;
              end else begin
                underrun_n  = 1'b1;
                state_n     = ABORT;
                cnt_n       = 5'd0;
                hold_full_n = 1'b0;
              end
            end
          end
        end
        FCS: begin
          tx_en_n = 1'b1;
          if (ones == 3'd5) begin
            txd_n  = 1'b0;
            ones_n = 3'd0;
            if (cnt == 5'd16) begin
              state_n   = TRAIL;
              cnt_n     = 5'd0;
              bit_cnt_n = 3'd0;
            end
          end else begin
            txd_n  = fcs_bit;
            ones_n = fcs_bit ? ones + 3'd1 : 3'd0;
            // A final FCS bit that completes five ones still owes a stuff cell before the flag.
            if (cnt == 5'd15 && !(fcs_bit && ones == 3'd4)) begin
              state_n   = TRAIL;
              cnt_n     = 5'd0;
              bit_cnt_n = 3'd0;
            end else begin
              cnt_n = cnt + 5'd1;
            end
          end
        end
        TRAIL: begin
          txd_n     = FLAG[bit_cnt];
          tx_en_n   = 1'b1;
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            if (cnt == 5'(TRAIL_FLAGS - 1)) begin
              state_n = IDLE;
              done_n  = 1'b1;
            end else begin
              cnt_n = cnt + 5'd1;
            end
          end
        end
        ABORT: begin
          txd_n   = 1'b1;
          tx_en_n = 1'b1;
          if (cnt == 5'd7) begin
            state_n     = IDLE;
            hold_full_n = 1'b0;
            bit_cnt_n   = 3'd0;
          end else begin
            cnt_n = cnt + 5'd1;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (reload) begin
      shreg_n     = hold;
      cur_last_n  = hold_last;
      hold_full_n = 1'b0;
    end

    case (state)
      IDLE:       tx_ready = running && !hold_full;
      LEAD, DATA: tx_ready = !last_acc && (!hold_full || reload);
      default:    tx_ready = 1'b0;
    endcase

    accept = tx_valid && tx_ready;
    if (accept) begin
      hold_n      = tx_data;
      hold_full_n = 1'b1;
      hold_last_n = tx_last;
      if (state == IDLE) begin
        last_acc_n = tx_last;
        lfsr_n     = 16'hFFFF;
        ones_n     = 3'd0;
`ifndef TX_IDLE_FLAGS_EN
        state_n    = LEAD;
        cnt_n      = 5'd0;
        bit_cnt_n  = 3'd0;
`endif
      end else if (tx_last) begin
        last_acc_n = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_econet_tx_framer.sv
// Directed bench for econet_tx_framer: captures the line stream per bit cell and checks it
// against hand-computed words, a stuffing/CRC stream model and the CRC-CCITT residue.
module tb_econet_tx_framer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bit_en = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_last = 1'b0;
  logic       tx_abort = 1'b0;
  logic       tx_ready, txd, tx_en, busy, done, underrun;
  logic [2:0] fsm_state;

  int total = 0;
  int bad = 0;
  logic ben_run = 1'b0;
  int ben_phase = 0;
  int done_cnt = 0;
  int und_cnt = 0;
  logic [0:0] cap_q[$];
  logic [0:0] exp_q[$];
  logic [7:0] fr_bytes[$];

  econet_tx_framer #(.LEAD_FLAGS(2), .TRAIL_FLAGS(1)) dut (
    .clk       (clk),
    .reset     (reset),
    .bit_en    (bit_en),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_last   (tx_last),
    .tx_ready  (tx_ready),
    .tx_abort  (tx_abort),
    .txd       (txd),
    .tx_en     (tx_en),
    .busy      (busy),
    .done      (done),
    .underrun  (underrun),
    .fsm_state (fsm_state)
  );

  // clock and bit-cell strobe (one clk in four)
  always #5 clk = ~clk;

  initial forever begin
    @(negedge clk);
    if (ben_run) begin
      ben_phase = (ben_phase + 1) % 4;
      bit_en = (ben_phase == 0);
    end else begin
      bit_en = 1'b0;
    end
  end

  // line monitor: one entry per active bit cell, plus pulse counters
  initial begin : monitor
    logic ben_s;
    forever begin
      @(posedge clk);
      ben_s = bit_en;
      #1;
      if (ben_s && tx_en) cap_q.push_back(txd);
      if (done) done_cnt++;
      if (underrun) und_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    logic f;
    f = b ^ c[15];
    return {c[14:0], 1'b0} ^ (f ? 16'h1021 : 16'h0000);
  endfunction

  task automatic push_stuffed(input logic b, inout int ones);
    exp_q.push_back(b);
    ones = b ? ones + 1 : 0;
    if (ones == 5) begin
      exp_q.push_back(1'b0);
      ones = 0;
    end
  endtask

  task automatic build_exp();
    logic [15:0] crc;
    logic [7:0] flag;
    logic [7:0] byt;
    int ones;
    crc = 16'hFFFF;
    flag = 8'h7E;
    ones = 0;
    exp_q.delete();
    for (int f = 0; f < 2; f++)
      for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
    for (int k = 0; k < fr_bytes.size(); k++) begin
      byt = fr_bytes[k];
      for (int i = 0; i < 8; i++) begin
        crc = crc_step(crc, byt[i]);
        push_stuffed(byt[i], ones);
      end
    end
    for (int i = 15; i >= 0; i--) push_stuffed(~crc[i], ones);
    for (int i = 0; i < 8; i++) exp_q.push_back(flag[i]);
  endtask

  // driver tasks
  task automatic send_byte(input logic [7:0] d, input logic last, output logic ok);
    ok = 1'b0;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    tx_last = last;
    for (int i = 0; i < 400; i++) begin
      #1;
      if (tx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_last = 1'b0;
  endtask

  task automatic wait_idle(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_cells(input int n, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (cap_q.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_idle(input string tag);
    repeat (8) @(negedge clk);
    check({tag, "_txen_off"}, tx_en, 1'b0);
    check({tag, "_txd_mark"}, txd, 1'b1);
  endtask

  task automatic check_frame(input string tag, input logic [31:0] data_val, input int cells);
    int n;
    int nmis;
    int ones;
    logic [31:0] w;
    logic [15:0] crc;
    logic b;
    n = cap_q.size();
    check({tag, "_len"}, n, exp_q.size());
    nmis = 0;
    for (int i = 0; i < n && i < exp_q.size(); i++) if (cap_q[i] !== exp_q[i]) nmis++;
    check({tag, "_bit_errors"}, nmis, 0);
    w = '0;
    for (int i = 0; i < 16 && i < n; i++) w[i] = cap_q[i];
    check({tag, "_lead_flags"}, w, 32'h7E7E);
    w = '0;
    for (int i = 0; i < cells && 16 + i < n; i++) w[i] = cap_q[16 + i];
    check({tag, "_data_cells"}, w, data_val);
    w = '0;
    for (int i = 0; i < 8 && n >= 8; i++) w[i] = cap_q[n - 8 + i];
    check({tag, "_trail_flag"}, w, 32'h7E);
    crc = 16'hFFFF;
    ones = 0;
    for (int i = 16; i < n - 8; i++) begin
      b = cap_q[i];
      if (ones == 5 && b == 1'b0) begin
        ones = 0;
        continue;
      end
      crc = crc_step(crc, b);
      ones = b ? ones + 1 : 0;
    end
    check({tag, "_residue"}, crc, 16'h1D0F);
    check({tag, "_done_pulses"}, done_cnt, 1);
    check({tag, "_underruns"}, und_cnt, 0);
  endtask

  task automatic do_frame(input string tag, input logic [31:0] data_val, input int cells);
    logic ok;
    build_exp();
    cap_q.delete();
    done_cnt = 0;
    und_cnt = 0;
    for (int k = 0; k < fr_bytes.size(); k++) begin
      send_byte(fr_bytes[k], k == fr_bytes.size() - 1, ok);
      check({tag, "_accept"}, ok, 1'b1);
    end
    wait_idle(ok);
    check({tag, "_end"}, ok, 1'b1);
    check_frame(tag, data_val, cells);
    check_idle(tag);
  endtask

  initial begin : main
    logic ok;
    logic [31:0] w;
    int nmis;

    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tx_en", tx_en, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    reset = 1'b0;
    ben_run = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check("idle_ready", tx_ready, 1'b1);

    fr_bytes = '{8'h01, 8'h02};
    do_frame("f0102", 32'h0000_0201, 16);
    fr_bytes = '{8'hFF};
    do_frame("fff", 32'h0000_01DF, 9);
    fr_bytes = '{8'h7C, 8'h0F};
    do_frame("f7c0f", 32'h0000_1E7C, 17);
    fr_bytes = '{8'hE0, 8'h03};
    do_frame("fe003", 32'h0000_03E0, 17);

    // underrun: host goes quiet after one non-final byte
    cap_q.delete();
    done_cnt = 0;
    und_cnt = 0;
    send_byte(8'h55, 1'b0, ok);
    check("und_accept", ok, 1'b1);
    wait_idle(ok);
    check("und_end", ok, 1'b1);
    check("und_len", cap_q.size(), 32);
    w = '0;
    for (int i = 0; i < 32 && i < cap_q.size(); i++) w[i] = cap_q[i];
    check("und_stream", w, 32'hFF55_7E7E);
    check("und_pulses", und_cnt, 1);
    check("und_done", done_cnt, 0);
    check_idle("und");

    // abort during FCS bit 3 of a one-byte frame
    fr_bytes = '{8'h01};
    build_exp();
    cap_q.delete();
    done_cnt = 0;
    und_cnt = 0;
    send_byte(8'h01, 1'b1, ok);
    check("abt_accept", ok, 1'b1);
    wait_cells(27, ok);
    check("abt_reach_fcs", ok, 1'b1);
    tx_abort = 1'b1;
    wait_idle(ok);
    tx_abort = 1'b0;
    check("abt_end", ok, 1'b1);
    check("abt_len", cap_q.size(), 35);
    nmis = 0;
    for (int i = 0; i < 27 && i < cap_q.size(); i++) if (cap_q[i] !== exp_q[i]) nmis++;
    for (int i = 27; i < 35 && i < cap_q.size(); i++) if (cap_q[i] !== 1'b1) nmis++;
    check("abt_bit_errors", nmis, 0);
    check("abt_done", done_cnt, 0);
    check("abt_underrun", und_cnt, 0);
    check_idle("abt");
    fr_bytes = '{8'h01, 8'h02};
    do_frame("after_abt", 32'h0000_0201, 16);

    // reset in the middle of data
    cap_q.delete();
    send_byte(8'hAA, 1'b0, ok);
    check("rmid_accept", ok, 1'b1);
    wait_cells(20, ok);
    check("rmid_in_data", ok, 1'b1);
    reset = 1'b1;
    #1;
    check("rmid_txd", txd, 1'b1);
    check("rmid_tx_en", tx_en, 1'b0);
    check("rmid_busy", busy, 1'b0);
    check("rmid_ready", tx_ready, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    fr_bytes = '{8'h01, 8'h02};
    do_frame("after_rst", 32'h0000_0201, 16);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
